// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for hazards that forwarding cannot resolve; optional perf counters under HAZARD_PERF_CNT_EN
module hazard_ctrl #(
`ifdef HAZARD_PERF_CNT_EN
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 16
`else
    parameter int MISS_TIMEOUT = 255
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] if_id_opcode,
    input  logic [3:0] if_id_rs,
    input  logic [3:0] if_id_rt,
    input  logic [3:0] id_ex_rd,
    input  logic       id_ex_memRead,
    input  logic       id_ex_regWrite,
    input  logic [3:0] ex_mem_rd,
    input  logic       ex_mem_memRead,
    input  logic       branch_taken,
    input  logic       icache_miss,
    input  logic       icache_ready,
    input  logic       dcache_miss,
    input  logic       dcache_ready,
    output logic       pc_write_en,
    output logic       if_id_write_en,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       pipe_freeze,
    output logic       imiss_abort,
    output logic       halted,
    output logic       miss_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    typedef enum logic [2:0] {RUN, DMISS, IMISS, DRAIN, HALT} state_t;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam int MW = $clog2(MISS_TIMEOUT + 1);
    state_t        r_state, w_next;
    logic          r_pend, w_pend_next;
    logic [1:0]    r_dcnt, w_dcnt_next;
    logic [MW-1:0] r_mcnt;
    logic          r_timeout;
    logic          w_lu, w_br, w_miss;
    assign w_lu = id_ex_memRead && id_ex_rd != 4'd0 &&
                  (id_ex_rd == if_id_rs || (id_ex_rd == if_id_rt && if_id_opcode != OP_SW));
    assign w_br = if_id_opcode == OP_BR && if_id_rs != 4'd0 &&
                  ((id_ex_regWrite && id_ex_rd == if_id_rs) || (ex_mem_memRead && ex_mem_rd == if_id_rs));
    assign w_miss = r_state == DMISS || r_state == IMISS;
    assign miss_timeout = r_timeout;
    // next-state and control outputs; rst forces the NOP-injecting reset pattern
    always_comb begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pipe_freeze    = 1'b0;
        imiss_abort    = 1'b0;
        halted         = 1'b0;
        w_next         = r_state;
        w_pend_next    = r_pend;
        w_dcnt_next    = r_dcnt;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (dcache_miss) begin
                        pipe_freeze = 1'b1;
                        w_next      = DMISS;
                        w_pend_next = icache_miss;
                    end else if (w_lu || w_br) begin
                        id_ex_bubble = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                        pc_write_en = 1'b1;
                    end else if (icache_miss) begin
                        if_id_flush = 1'b1;
                        w_next      = IMISS;
                    end else if (if_id_opcode == OP_HLT) begin
                        if_id_flush = 1'b1;
                        w_next      = DRAIN;
                        w_dcnt_next = 2'd0;
                    end else begin
                        pc_write_en    = 1'b1;
                        if_id_write_en = 1'b1;
                    end
                end
                DMISS: begin
                    if (dcache_ready) begin
                        w_next      = ((r_pend || icache_miss) && !icache_ready) ? IMISS : RUN;
                        w_pend_next = 1'b0;
                    end else begin
                        pipe_freeze = 1'b1;
                        w_pend_next = r_pend || icache_miss;
                    end
                end
                IMISS: begin
                    if_id_flush = 1'b1;
                    if (dcache_miss) begin
                        pipe_freeze = 1'b1;
                        w_pend_next = 1'b1;
                        w_next      = DMISS;
                    end else if (branch_taken) begin
                        pc_write_en = 1'b1;
                        imiss_abort = 1'b1;
                        w_next      = RUN;
                    end else if (icache_ready) begin
                        w_next = RUN;
                    end
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    if (dcache_miss) begin
                        pipe_freeze = 1'b1;
                    end else begin
                        w_dcnt_next = r_dcnt + 2'd1;
                        w_next      = (r_dcnt == 2'd2) ? HALT : DRAIN;
                    end
                end
                HALT: begin
                    if_id_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: w_next = RUN;
            endcase
        end
    end
    // state, pending fetch miss, drain count and sticky miss timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_pend    <= 1'b0;
            r_dcnt    <= 2'd0;
            r_mcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pend  <= w_pend_next;
            r_dcnt  <= w_dcnt_next;
            if ((w_next == DMISS || w_next == IMISS) && w_next != r_state)
                r_mcnt <= '0;
            else if (w_miss && r_mcnt != MW'(MISS_TIMEOUT))
                r_mcnt <= r_mcnt + 1'b1;
            if (w_miss && r_mcnt == MW'(MISS_TIMEOUT - 1))
                r_timeout <= 1'b1;
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    logic w_bflush;
    assign w_bflush = r_state == RUN && !dcache_miss && !(w_lu || w_br) && branch_taken;
    // saturating stall and branch-flush counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write_en && r_state != HALT && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (w_bflush && !(&flush_count))
                flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule
